// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states, digit limits
// and the active-low seven-segment code table used when STOPWATCH_SEG7_EN is set.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] ONES_MAX = 4'd9;
  localparam logic [BCD_W-1:0] TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active low; entries 10..15 are blank.
  localparam logic [15:0][6:0] SEG7_CODES = {
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [6:0]       seg
);

  assign seg = SEG7_CODES[digit];

endmodule

// File: rtl/stopwatch_bcd.sv
// mm:ss BCD stopwatch advanced by upstream tick pulses, with synchronised
// start/stop and clear buttons. Optional seven-segment outputs under STOPWATCH_SEG7_EN.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int MAX_MINUTES   = 60
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             tick,
  input  logic             start_stop,
  input  logic             clear,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             running,
  output logic             overflow
`ifdef STOPWATCH_SEG7_EN
  ,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3
`endif
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [BCD_W-1:0] MT_LAST = BCD_W'((MAX_MINUTES - 1) / 10);
  localparam logic [BCD_W-1:0] MO_LAST = BCD_W'((MAX_MINUTES - 1) % 10);

  state_t           state_r, state_s;
  logic [1:0]       ss_sync_r, clr_sync_r;
  logic             ss_prev_r, clr_prev_r;
  logic             ss_edge_s, clr_edge_s;
  logic             zero_s, count_s, sec_inc_s;
  logic [PRE_W-1:0] pre_r, pre_s;
  logic [BCD_W-1:0] so_s, st_s, mo_s, mt_s;
  logic             ovf_s;

  assign ss_edge_s  = ss_sync_r[1]  & ~ss_prev_r;
  assign clr_edge_s = clr_sync_r[1] & ~clr_prev_r;
  assign count_s    = tick & (state_r == RUN);

  // Button synchronisers and edge-detect history.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      ss_sync_r  <= 2'b00;
      clr_sync_r <= 2'b00;
      ss_prev_r  <= 1'b0;
      clr_prev_r <= 1'b0;
    end else begin
      ss_sync_r  <= {ss_sync_r[0], start_stop};
      clr_sync_r <= {clr_sync_r[0], clear};
      ss_prev_r  <= ss_sync_r[1];
      clr_prev_r <= clr_sync_r[1];
    end
  end

  // Next state; in RUN the clear edge is ignored so start/stop always wins there.
  always_comb begin
    state_s = state_r;
    zero_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (clr_edge_s) begin
          state_s = IDLE;
          zero_s  = 1'b1;
        end else if (ss_edge_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (ss_edge_s) begin
          state_s = PAUSE;
        end else begin
          state_s = RUN;
        end
      end
      PAUSE: begin
        if (clr_edge_s) begin
          state_s = IDLE;
          zero_s  = 1'b1;
        end else if (ss_edge_s) begin
          state_s = RUN;
        end else begin
          state_s = PAUSE;
        end
      end
      default: begin
        state_s = IDLE;
        zero_s  = 1'b1;
      end
    endcase
  end

  // Prescaler and ripple-carry digit chain, qualified by the current state.
  always_comb begin
    pre_s     = pre_r;
    so_s      = sec_ones;
    st_s      = sec_tens;
    mo_s      = min_ones;
    mt_s      = min_tens;
    ovf_s     = overflow;
    sec_inc_s = 1'b0;
    if (zero_s) begin
      pre_s = {PRE_W{1'b0}};
      so_s  = 4'd0;
      st_s  = 4'd0;
      mo_s  = 4'd0;
      mt_s  = 4'd0;
      ovf_s = 1'b0;
    end else if (count_s) begin
      if (pre_r == PRE_MAX) begin
        pre_s     = {PRE_W{1'b0}};
        sec_inc_s = 1'b1;
      end else begin
        pre_s = pre_r + PRE_ONE;
      end
    end else begin
      pre_s = pre_r;
    end

    if (sec_inc_s) begin
      if (sec_ones == ONES_MAX) begin
        so_s = 4'd0;
        if (sec_tens == TENS_MAX) begin
          st_s = 4'd0;
          if ((min_tens == MT_LAST) && (min_ones == MO_LAST)) begin
            mo_s  = 4'd0;
            mt_s  = 4'd0;
            ovf_s = 1'b1;
          end else if (min_ones == ONES_MAX) begin
            mo_s = 4'd0;
            mt_s = min_tens + 4'd1;
          end else begin
            mo_s = min_ones + 4'd1;
          end
        end else begin
          st_s = sec_tens + 4'd1;
        end
      end else begin
        so_s = sec_ones + 4'd1;
      end
    end else begin
      ovf_s = ovf_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_r  <= IDLE;
      pre_r    <= {PRE_W{1'b0}};
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_r  <= state_s;
      pre_r    <= pre_s;
      sec_ones <= so_s;
      sec_tens <= st_s;
      min_ones <= mo_s;
      min_tens <= mt_s;
      running  <= (state_s == RUN);
      overflow <= ovf_s;
    end
  end

`ifdef STOPWATCH_SEG7_EN
  bcd_to_seg7 u_seg0 (.digit(sec_ones), .seg(hex0));
  bcd_to_seg7 u_seg1 (.digit(sec_tens), .seg(hex1));
  bcd_to_seg7 u_seg2 (.digit(min_ones), .seg(hex2));
  bcd_to_seg7 u_seg3 (.digit(min_tens), .seg(hex3));
`endif

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Downstream consumer of the modulo-k counter's `rollover` pulse. Each tick pulse advances an mm:ss time kept as four BCD digits.
- Start/stop/clear control comes from two raw pushbutton levels, each synchronised and edge-detected internally.
- Digit outputs feed the board's seven-segment display path.

Parameters:
- TICKS_PER_SEC, 1, number of `tick` pulses per one-second increment; legal range 1..1024.
- MAX_MINUTES, 60, minute count wraps at this value; legal range 1..100.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- aclr  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle pulse from the upstream counter's `rollover`; sampled every clk.
- start_stop  input  1  raw active-high button level, asynchronous to clk.
- clear  input  1  raw active-high button level, asynchronous to clk.
- sec_ones  output  4  BCD seconds units, 0..9.
- sec_tens  output  4  BCD seconds tens, 0..5.
- min_ones  output  4  BCD minutes units, 0..9.
- min_tens  output  4  BCD minutes tens, 0..9.
- running  output  1  high while in state RUN.
- overflow  output  1  sticky; set when time wraps past the maximum.

Behaviour:
- Reset: aclr low forces asynchronously:
  - state IDLE
  - all digits 0, prescaler 0
  - running 0, overflow 0
  - synchroniser and edge-detect flops 0
- Input conditioning:
  - start_stop and clear each pass through a 2-flop synchroniser, then a rising-edge detector (sync AND NOT previous).
  - The result is a one-cycle ss_edge / clr_edge.
  - Latency: a state change is visible at the 3rd rising clk edge after the raw input rises.
  - Holding a button high produces exactly one edge.
- State machine: Moore, states IDLE, RUN, PAUSE.
  - IDLE: ss_edge -> RUN. clr_edge -> IDLE, re-zeroes digits, clears overflow.
  - RUN: ss_edge -> PAUSE. clr_edge is ignored.
  - PAUSE:
    - ss_edge -> RUN; prescaler and digits are retained.
    - clr_edge -> IDLE; zeroes digits and prescaler, clears overflow.
  - ss_edge and clr_edge in the same cycle:
    - IDLE or PAUSE: clear wins and the block goes to IDLE.
    - RUN: ss_edge applies and the block goes to PAUSE.
- running: registered, equal to (state == RUN).
- Counting: qualified by the current state, not the next state.
  - A tick in a cycle whose current state is RUN is counted, including the cycle in which ss_edge moves RUN -> PAUSE.
  - A tick in the cycle where IDLE/PAUSE -> RUN is not counted.
- Prescaler: width clog2(TICKS_PER_SEC), minimum 1 bit.
  - On a counted tick: if prescaler == TICKS_PER_SEC-1, reset it to 0 and issue a sec_inc; otherwise increment it.
  - With TICKS_PER_SEC=1, every counted tick is a sec_inc.
- Digit chain on sec_inc: ripple carry inside a single cycle.
  - sec_ones 9 -> 0, carry out.
  - sec_tens 5 -> 0, carry out.
  - min_ones 9 -> 0, carry out.
  - min_tens increments.
- Minute wrap: if minutes == MAX_MINUTES-1 and the seconds carry out:
  - All four digits go to 0 in the same cycle.
  - overflow is set to 1 and stays set until clr_edge in IDLE/PAUSE, or reset.
- Outside RUN, digits and prescaler hold.
- Reset asserted mid-count returns everything to the reset values immediately, regardless of clk.

Optional Feature:
- Macro STOPWATCH_SEG7_EN.
- When defined:
  - Adds outputs hex0..hex3, each 7 bits, active-low segments {g,f,e,d,c,b,a}.
  - hex0 = sec_ones ... hex3 = min_tens.
  - Decoding is combinational from the digit registers, so there is no extra latency.
  - Codes 10..15 display blank (7'h7F).
- When undefined: the hex ports and the decoder logic are absent; all other behaviour is identical.

Decomposition:
- Package stopwatch_pkg holds:
  - state typedef: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10
  - BCD_W=4
  - digit limit constants: 9 and 5
  - the seven-segment code constant table
- One sub-module is natural: bcd_to_seg7.
  - 4-bit digit in, 7-bit active-low segments out.
  - Instantiated four times, only under STOPWATCH_SEG7_EN.

Test Plan:
- Reset: with aclr=0 and toggling clk, all digits, running and overflow read 0. Then aclr=1 and 20 ticks with no start: digits stay 00:00.
- Basic run (TICKS_PER_SEC=1): pulse start_stop, wait 3 clks, then apply 10 ticks. Expect running=1 and time 00:10 (sec_tens=1, sec_ones=0).
- Pause and clear:
  - Start, 5 ticks, pulse start_stop, 3 more ticks: time holds at 00:05 with running=0.
  - Pulse clear: 00:00 and state IDLE.
  - Pulse clear while in RUN: time is unchanged.
- Wrap (MAX_MINUTES=60):
  - Start and apply 3599 ticks: 59:59, overflow=0.
  - One more tick: 00:00, overflow=1.
  - Pause then clear: overflow=0.
- Edge cases:
  - A tick in the same cycle as the internal ss_edge while in RUN is counted.
  - Holding start_stop high for 50 clks gives a single transition.
  - Simultaneous ss_edge and clr_edge in PAUSE leads to IDLE at 00:00.
- Prescaler (TICKS_PER_SEC=4): start, 7 ticks gives 00:01. Pause, resume, 1 tick gives 00:02. Drop aclr mid-run: all outputs 0 immediately.
